// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
// Latches floor calls into a pending bitmap and hands out one target floor at
// a time to the elevator, in LOOK order: keep sweeping while calls remain ahead
// of the car, otherwise turn around.
// Build option: define SCHED_DWELL_EN to build the DOOR state and the dwell
// counter. Without it, arrival returns straight to IDLE and door_open is a
// one-cycle pulse.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = 4,
  parameter int DWELL_CYCLES = 10000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  call_err
);

  typedef enum logic [1:0] {IDLE, SELECT, MOVE, DOOR} state_t;

  // Elaboration-time sanity check on the parameter set.
  if (DWELL_CYCLES < 1 || NUM_FLOORS > 16 || NUM_FLOORS > (1 << FLOOR_W)) begin : g_bad_cfg
    $error("elevator_request_scheduler: unsupported parameter set");
  end

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_floor_q, target_floor_d;
  logic                  target_valid_q, target_valid_d;
  logic                  dir_up_q, dir_up_d;
  logic                  door_open_q, door_open_d;
  logic                  call_err_q, call_err_d;

`ifdef SCHED_DWELL_EN
  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
`endif

  logic [NUM_FLOORS-1:0] call_hit, here_vec, above_vec, below_vec, clr_vec;
  logic [FLOOR_W-1:0]    near_above, near_below;
  logic                  arrive, absorb, absorb_window;

  // Per-floor decode: call match, position of each pending floor relative to
  // the car, and the arrival clear. Out-of-range calls match no floor.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
    assign call_hit[gi]  = call_valid && (call_floor == FLOOR_W'(gi));
    assign here_vec[gi]  = pending_q[gi] && (car_floor == FLOOR_W'(gi));
    assign above_vec[gi] = pending_q[gi] && (FLOOR_W'(gi) > car_floor);
    assign below_vec[gi] = pending_q[gi] && (FLOOR_W'(gi) < car_floor);
    assign clr_vec[gi]   = arrive && (target_floor_q == FLOOR_W'(gi));
  end

  // Priority scans: lowest pending floor above the car, highest below it.
  always_comb begin
    near_above = '0;
    near_below = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (above_vec[i]) near_above = FLOOR_W'(i);
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below_vec[i]) near_below = FLOOR_W'(i);
    end
  end

  // Arrival, door-window absorption and the pending/error updates.
  always_comb begin
`ifdef SCHED_DWELL_EN
    absorb_window = (state_q == DOOR);
`else
    absorb_window = door_open_q;
`endif
    arrive     = (state_q == MOVE) && car_idle && (car_floor == target_floor_q);
    absorb     = call_valid && (call_floor == car_floor) && absorb_window;
    // Clear is applied last so a same-edge call to the arrival floor is lost.
    pending_d  = (pending_q | (absorb ? '0 : call_hit)) & ~clr_vec;
    call_err_d = call_valid && !(|call_hit);
  end

  // Dispatch FSM: next state, target selection, direction and door control.
  always_comb begin
    state_d        = state_q;
    target_floor_d = target_floor_q;
    target_valid_d = target_valid_q;
    dir_up_d       = dir_up_q;
`ifdef SCHED_DWELL_EN
    door_open_d    = door_open_q;
    dwell_cnt_d    = dwell_cnt_q;
`else
    door_open_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|pending_q) state_d = SELECT;
      end
      SELECT: begin
        target_valid_d = 1'b1;
        state_d        = MOVE;
        if (|here_vec) begin
          target_floor_d = car_floor;
        end else if (dir_up_q) begin
          if (|above_vec) begin
            target_floor_d = near_above;
          end else if (|below_vec) begin
            target_floor_d = near_below;
            dir_up_d       = 1'b0;
          end else begin
            target_floor_d = near_above;
            dir_up_d       = 1'b1;
          end
        end else begin
          if (|below_vec) begin
            target_floor_d = near_below;
          end else if (|above_vec) begin
            target_floor_d = near_above;
            dir_up_d       = 1'b1;
          end else begin
            target_floor_d = near_below;
            dir_up_d       = 1'b0;
          end
        end
      end
      MOVE: begin
        if (arrive) begin
          target_valid_d = 1'b0;
          door_open_d    = 1'b1;
`ifdef SCHED_DWELL_EN
          dwell_cnt_d    = DWELL_RELOAD;
          state_d        = DOOR;
`else
          state_d        = IDLE;
`endif
        end
      end
`ifdef SCHED_DWELL_EN
      DOOR: begin
        if (absorb) begin
          dwell_cnt_d = DWELL_RELOAD;
        end else if (dwell_cnt_q == '0) begin
          door_open_d = 1'b0;
          state_d     = IDLE;
        end else begin
          dwell_cnt_d = dwell_cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      target_floor_q <= '0;
      target_valid_q <= 1'b0;
      dir_up_q       <= 1'b1;
      door_open_q    <= 1'b0;
      call_err_q     <= 1'b0;
`ifdef SCHED_DWELL_EN
      dwell_cnt_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      target_floor_q <= target_floor_d;
      target_valid_q <= target_valid_d;
      dir_up_q       <= dir_up_d;
      door_open_q    <= door_open_d;
      call_err_q     <= call_err_d;
`ifdef SCHED_DWELL_EN
      dwell_cnt_q    <= dwell_cnt_d;
`endif
    end
  end

  assign target_floor = target_floor_q;
  assign target_valid = target_valid_q;
  assign dir_up       = dir_up_q;
  assign door_open    = door_open_q;
  assign pending      = pending_q;
  assign call_err     = call_err_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Testbench for elevator_request_scheduler: a per-cycle vector table followed
// by hand-written multi-cycle sequences (LOOK order, current-floor priority,
// door absorption). Expected door length follows SCHED_DWELL_EN.
module tb_elevator_request_scheduler;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int DW = 4;
`ifdef SCHED_DWELL_EN
  localparam int DOOR_LEN = DW;
`else
  localparam int DOOR_LEN = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          call_valid;
  logic [FW-1:0] call_floor;
  logic [FW-1:0] car_floor;
  logic          car_idle;
  logic [FW-1:0] target_floor;
  logic          target_valid;
  logic          dir_up;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          call_err;

  int checks   = 0;
  int failures = 0;

  elevator_request_scheduler #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW),
    .DWELL_CYCLES(DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .call_valid  (call_valid),
    .call_floor  (call_floor),
    .car_floor   (car_floor),
    .car_idle    (car_idle),
    .target_floor(target_floor),
    .target_valid(target_valid),
    .dir_up      (dir_up),
    .door_open   (door_open),
    .pending     (pending),
    .call_err    (call_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          cv;
    logic [FW-1:0] cf;
    logic [FW-1:0] car;
    logic          idle;
    logic [NF-1:0] pend;
    logic [FW-1:0] tf;
    logic          tv;
    logic          dir;
    logic          door;
    logic          err;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [FW-1:0] cf);
    call_valid = cv;
    call_floor = cf;
  endtask

  // Wait (bounded) for a dispatch and check its floor and direction.
  task automatic wait_dispatch(input string nm, input int exp_tf, input int exp_dir);
    int n = 0;
    while (!target_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " dispatched"}, int'(target_valid), 1);
    chk({nm, " target"}, int'(target_floor), exp_tf);
    chk({nm, " dir_up"}, int'(dir_up), exp_dir);
  endtask

  // Bring the car to rest at the floor, then measure the door-open length.
  task automatic arrive(input string nm, input int fl);
    int n = 1;
    int guard = 0;
    car_floor = FW'(fl);
    car_idle  = 1'b1;
    tick();
    chk({nm, " door rises"}, int'(door_open), 1);
    chk({nm, " pending cleared"}, int'(pending[fl]), 0);
    while (guard < 50) begin
      tick();
      guard++;
      if (!door_open) break;
      n++;
    end
    chk({nm, " door cycles"}, n, DOOR_LEN);
  endtask

  initial begin
    // rst cv cf car idle | pend tf tv dir door err
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3,  4'd0, 1'b1, 10'h008, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 10'h008, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 10'h008, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  4'd3, 1'b0, 10'h008, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  4'd3, 1'b1, 10'h000, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 4'd0,  4'd3, 1'b1, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd12, 4'd0, 1'b1, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 4'd10, 4'd0, 1'b1, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'd8,  4'd0, 1'b1, 10'h100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 10'h100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'd8,  4'd0, 1'b1, 10'h100, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd15, 4'd0, 1'b1, 10'h100, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 4'd0,  4'd0, 1'b1, 10'h001, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 10'h001, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 10'h001, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; call_valid = 1'b0; call_floor = '0; car_floor = '0; car_idle = 1'b1;
    tick();

    // Table: one vector per clock edge.
    for (int i = 0; i < 19; i++) begin
      reset      = vecs[i].rst;
      call_valid = vecs[i].cv;
      call_floor = vecs[i].cf;
      car_floor  = vecs[i].car;
      car_idle   = vecs[i].idle;
      tick();
      chk($sformatf("v%0d pending", i), int'(pending), int'(vecs[i].pend));
      chk($sformatf("v%0d target_floor", i), int'(target_floor), int'(vecs[i].tf));
      chk($sformatf("v%0d target_valid", i), int'(target_valid), int'(vecs[i].tv));
      chk($sformatf("v%0d dir_up", i), int'(dir_up), int'(vecs[i].dir));
      chk($sformatf("v%0d door_open", i), int'(door_open), int'(vecs[i].door));
      chk($sformatf("v%0d call_err", i), int'(call_err), int'(vecs[i].err));
      $display("vector %0d applied: pending=%03h target=%0d valid=%0d door=%0d err=%0d",
               i, pending, target_floor, target_valid, door_open, call_err);
    end

    // Door length on the first arrival of a clean run.
    reset = 1'b1; drive(1'b0, '0); car_floor = '0; car_idle = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 4'd3); tick(); drive(1'b0, '0);
    wait_dispatch("first", 3, 1);
    arrive("first", 3);
    chk("first pending empty", int'(pending), 0);
    $display("sequence first-call done");

    // LOOK ordering: car at 5 going up, calls 2, 7, 9.
    reset = 1'b1; drive(1'b0, '0); car_floor = 4'd5; car_idle = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 4'd2); tick();
    drive(1'b1, 4'd7); tick();
    drive(1'b1, 4'd9); tick();
    drive(1'b0, '0);
    chk("look pending", int'(pending), 'h284);
    wait_dispatch("look1", 7, 1); arrive("look1", 7);
    wait_dispatch("look2", 9, 1); arrive("look2", 9);
    wait_dispatch("look3", 2, 0); arrive("look3", 2);
    // Continue downward, then reverse when nothing is left below.
    drive(1'b1, 4'd4); tick();
    drive(1'b1, 4'd0); tick();
    drive(1'b0, '0);
    wait_dispatch("look4", 0, 0); arrive("look4", 0);
    wait_dispatch("look5", 4, 1); arrive("look5", 4);
    $display("sequence look done");

    // Reset returns the direction to up.
    reset = 1'b1;
    tick();
    chk("reset dir_up", int'(dir_up), 1);
    chk("reset door_open", int'(door_open), 0);
    reset = 1'b0;

    // Current-floor priority: car at 4, calls 6 then 4.
    car_floor = 4'd4; car_idle = 1'b1;
    drive(1'b1, 4'd6); tick();
    drive(1'b1, 4'd4); tick();
    drive(1'b0, '0);
    wait_dispatch("here1", 4, 1); arrive("here1", 4);
    wait_dispatch("here2", 6, 1);
    // Arrival at 6 with a same-edge call to 6: the clear wins.
    car_floor = 4'd6;
    drive(1'b1, 4'd6); tick(); drive(1'b0, '0);
    chk("arrive+call door", int'(door_open), 1);
    chk("arrive+call pending", int'(pending), 0);
    $display("sequence here-first done");

`ifdef SCHED_DWELL_EN
    begin
      int n = 1;
      int guard = 0;
      tick(); n++;
      tick(); n++;
      drive(1'b1, 4'd6); tick(); n++; drive(1'b0, '0);
      chk("absorb pending", int'(pending), 0);
      while (guard < 50) begin
        tick();
        guard++;
        if (!door_open) break;
        n++;
      end
      chk("absorb door cycles", n, DW + DW - 1);
    end
`else
    drive(1'b1, 4'd6); tick(); drive(1'b0, '0);
    chk("absorb pending", int'(pending), 0);
    chk("absorb door", int'(door_open), 0);
    tick();
    chk("absorb stays idle", int'(target_valid), 0);
`endif
    $display("sequence absorb done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
